// File: rtl/cpu7_inst_resp.sv
// Instruction-fetch responder: queues fetch requests, reads one 128-bit RAM line per
// request and returns in-order responses with optional added latency.
module cpu7_inst_resp #(
   parameter int DEPTH       = 4,
   parameter int IDX_W       = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               inst_req,
   input  logic [31:0]        inst_addr,
   input  logic               inst_cancel,
   output logic               inst_addr_ok,
   output logic               inst_valid,
   output logic [127:0]       inst_rdata,
   output logic [1:0]         inst_count,
   output logic               inst_uncache,
   output logic               inst_ex,
   output logic [5:0]         inst_exccode,
   output logic               ram_en,
   output logic [IDX_W-1:0]   ram_addr,
   input  logic [127:0]       ram_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [1:0]   q_off  [DEPTH];
   logic         q_unc  [DEPTH];
   logic         q_ex   [DEPTH];
   logic         q_rdy  [DEPTH];
   logic [2:0]   q_wait [DEPTH];
   logic [127:0] q_data [DEPTH];

   logic [PW-1:0] head, tail, sel, cap_idx;
   logic [CW-1:0] occ;
   logic          cap_vld, valid_q;
   logic          fault, full, push, pop, sel_vld, dlv;
   logic [127:0]  cap_data, dlv_data;
   logic          unused_addr;

   assign unused_addr  = ^inst_addr[28:IDX_W+4];

   assign fault        = inst_addr[1:0] != 2'b00;
   // The entry shown on inst_valid this cycle pops now, so it frees its slot.
   assign full         = (occ == CW'(DEPTH)) && !valid_q;
   assign push         = resetn && inst_req && !inst_cancel && !full;
   assign inst_addr_ok = push;
   assign ram_en       = push && !fault;
   assign ram_addr     = inst_addr[IDX_W+3:4];
   assign pop          = valid_q;
   assign inst_valid   = valid_q && !inst_cancel;

   assign cap_data = ram_rdata >> {q_off[cap_idx], 5'b00000};

   // While the head is being presented, the next candidate is the entry behind it.
   assign sel      = valid_q ? head + PW'(1) : head;
   assign sel_vld  = occ > (valid_q ? CW'(1) : CW'(0));
   assign dlv      = !inst_cancel && sel_vld && (q_wait[sel] == 3'd0) &&
                     (q_rdy[sel] || (cap_vld && (cap_idx == sel)));
   assign dlv_data = q_rdy[sel] ? q_data[sel] : cap_data;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         head    <= '0;
         tail    <= '0;
         occ     <= '0;
         cap_vld <= 1'b0;
         cap_idx <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_off[i]  <= '0;
            q_unc[i]  <= 1'b0;
            q_ex[i]   <= 1'b0;
            q_rdy[i]  <= 1'b0;
            q_wait[i] <= '0;
            q_data[i] <= '0;
         end
      end else if (inst_cancel) begin
         head    <= '0;
         tail    <= '0;
         occ     <= '0;
         cap_vld <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            q_rdy[i]  <= 1'b0;
            q_wait[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q_wait[i] != 3'd0) q_wait[i] <= q_wait[i] - 3'd1;
         end
         if (cap_vld) begin
            q_data[cap_idx] <= cap_data;
            q_rdy[cap_idx]  <= 1'b1;
         end
         if (push) begin
            q_off[tail]  <= inst_addr[3:2];
            q_unc[tail]  <= inst_addr[31:29] == 3'b101;
            q_ex[tail]   <= fault;
            q_rdy[tail]  <= fault;
            q_wait[tail] <= 3'(WAIT_CYCLES);
            q_data[tail] <= '0;
            tail         <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         occ     <= occ + CW'(push) - CW'(pop);
         cap_vld <= ram_en;
         cap_idx <= tail;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q      <= 1'b0;
         inst_rdata   <= '0;
         inst_count   <= '0;
         inst_uncache <= 1'b0;
         inst_ex      <= 1'b0;
         inst_exccode <= '0;
      end else begin
         valid_q <= dlv;
         if (dlv) begin
            inst_rdata   <= dlv_data;
            inst_count   <= (q_ex[sel] || q_unc[sel]) ? 2'd0 : 2'd3 - q_off[sel];
            inst_uncache <= q_unc[sel];
            inst_ex      <= q_ex[sel];
            inst_exccode <= q_ex[sel] ? 6'h08 : 6'h00;
         end
      end
   end

endmodule

// File: tb/tb_cpu7_inst_resp.sv
// Scoreboard bench: two responders (0 and 3 wait states) share one request stream;
// each accept pushes an expected response, each inst_valid pops and compares it.
module tb_cpu7_inst_resp;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 1'b0;
   logic        inst_cancel = 1'b0;
   logic [31:0] inst_addr = '0;

   logic         addr_ok [2];
   logic         valid   [2];
   logic [127:0] rdata   [2];
   logic [1:0]   cnt     [2];
   logic         unc     [2];
   logic         ex      [2];
   logic [5:0]   code    [2];
   logic         ram_en  [2];
   logic [9:0]   ram_addr[2];
   logic [127:0] ram_rdata[2];

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int           due;
      logic [127:0] data;
      logic [1:0]   cnt;
      logic         unc;
      logic         ex;
      logic [5:0]   code;
   } rsp_t;

   rsp_t sbq[2][$];

   cpu7_inst_resp #(.DEPTH(4), .IDX_W(10), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_cancel(inst_cancel), .inst_addr_ok(addr_ok[0]), .inst_valid(valid[0]),
      .inst_rdata(rdata[0]), .inst_count(cnt[0]), .inst_uncache(unc[0]), .inst_ex(ex[0]),
      .inst_exccode(code[0]), .ram_en(ram_en[0]), .ram_addr(ram_addr[0]),
      .ram_rdata(ram_rdata[0]));

   cpu7_inst_resp #(.DEPTH(4), .IDX_W(10), .WAIT_CYCLES(3)) dut3 (
      .clock(clock), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_cancel(inst_cancel), .inst_addr_ok(addr_ok[1]), .inst_valid(valid[1]),
      .inst_rdata(rdata[1]), .inst_count(cnt[1]), .inst_uncache(unc[1]), .inst_ex(ex[1]),
      .inst_exccode(code[1]), .ram_en(ram_en[1]), .ram_addr(ram_addr[1]),
      .ram_rdata(ram_rdata[1]));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] word_at(int j);
      return 32'hA500_0000 | 32'(j);
   endfunction

   function automatic logic [127:0] line_val(logic [9:0] l);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[32*k +: 32] = word_at(4 * int'(l) + k);
      return v;
   endfunction

   always @(posedge clock) begin
      for (int d = 0; d < 2; d++)
         if (ram_en[d]) ram_rdata[d] <= line_val(ram_addr[d]);
   end

   function automatic rsp_t model(logic [31:0] a, int due);
      rsp_t r;
      int   off;
      r.due  = due;
      r.ex   = a[1:0] != 2'b00;
      r.unc  = a[31:29] == 3'b101;
      r.data = '0;
      off    = int'(a[3:2]);
      if (r.ex) begin
         r.cnt  = 2'd0;
         r.code = 6'h08;
      end else begin
         for (int k = 0; k < 4; k++)
            if (k + off <= 3) r.data[32*k +: 32] = word_at(4 * int'(a[13:4]) + k + off);
         r.cnt  = r.unc ? 2'd0 : 2'(3 - off);
         r.code = 6'h00;
      end
      return r;
   endfunction

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      rsp_t e;
      for (int d = 0; d < 2; d++) begin
         if (!resetn) begin
            sbq[d].delete();
         end else begin
            if (valid[d]) begin
               check($sformatf("resp_expected%0d", d), 128'(sbq[d].size() > 0), 128'(1));
               if (sbq[d].size() > 0) begin
                  e = sbq[d].pop_front();
                  check($sformatf("latency%0d", d), 128'(cyc), 128'(e.due));
                  check($sformatf("rdata%0d", d), rdata[d], e.data);
                  check($sformatf("count%0d", d), 128'(cnt[d]), 128'(e.cnt));
                  check($sformatf("uncache%0d", d), 128'(unc[d]), 128'(e.unc));
                  check($sformatf("ex%0d", d), 128'(ex[d]), 128'(e.ex));
                  if (e.ex) check($sformatf("exccode%0d", d), 128'(code[d]), 128'(e.code));
               end
            end
            if (inst_cancel) sbq[d].delete();
            if (addr_ok[d]) begin
               e = model(inst_addr, cyc + 2 + (d == 0 ? 0 : 3));
               check($sformatf("ram_en%0d", d), 128'(ram_en[d]), 128'(!e.ex));
               if (!e.ex) check($sformatf("ram_addr%0d", d), 128'(ram_addr[d]), 128'(inst_addr[13:4]));
               sbq[d].push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_zero(string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_valid%0d", tag, d), 128'(valid[d]), 128'(0));
         check($sformatf("%s_addr_ok%0d", tag, d), 128'(addr_ok[d]), 128'(0));
         check($sformatf("%s_rdata%0d", tag, d), rdata[d], 128'(0));
         check($sformatf("%s_misc%0d", tag, d),
               128'({cnt[d], unc[d], ex[d], code[d], ram_en[d]}), 128'(0));
      end
   endtask

   // Hold a request until the 3-wait-state responder takes it; returns its accept cycle.
   task automatic req_until_dut3(input logic [31:0] a, output int acc);
      bit got = 0;
      acc = -100;
      inst_req  = 1'b1;
      inst_addr = a;
      for (int w = 0; w < 20 && !got; w++) begin
         @(negedge clock);
         if (addr_ok[1]) begin
            got = 1;
            acc = cyc;
         end else begin
            check("stall_no_ram_en", 128'(ram_en[1]), 128'(0));
         end
         @(posedge clock);
         #1;
      end
      if (!got) check("accept_timeout", 128'(0), 128'(1));
      inst_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] addrs[9];
      int          acc[5];
      int          exp_off[5];
      int          dummy;
      addrs   = '{32'h0, 32'h8, 32'hA000_0004, 32'h2, 32'h4, 32'hC,
                  32'h3FF0, 32'hA000_0018, 32'h1};
      exp_off = '{0, 1, 2, 3, 5};

      inst_req  = 1'b1;
      inst_addr = 32'h0;
      repeat (3) step();
      check_zero("reset");
      inst_req = 1'b0;
      resetn   = 1'b1;
      step();

      foreach (addrs[i]) begin
         inst_req  = 1'b1;
         inst_addr = addrs[i];
         step();
         inst_req = 1'b0;
         repeat (6) step();
      end

      foreach (addrs[i]) req_until_dut3(addrs[i], dummy);
      repeat (12) step();

      for (int i = 0; i < 5; i++) begin
         req_until_dut3(32'(i * 16), acc[i]);
         inst_req = 1'b1;
      end
      inst_req = 1'b0;
      for (int i = 1; i < 5; i++) check($sformatf("accept_slot%0d", i),
                                        128'(acc[i] - acc[0]), 128'(exp_off[i]));
      repeat (12) step();

      inst_req  = 1'b1;
      inst_addr = 32'h0;
      step();
      inst_addr = 32'h10;
      step();
      inst_req    = 1'b0;
      inst_cancel = 1'b1;
      @(negedge clock);
      check("cancel_kills_valid", 128'(valid[0]), 128'(0));
      step();
      inst_cancel = 1'b0;
      inst_req    = 1'b1;
      inst_addr   = 32'h40;
      step();
      inst_req = 1'b0;
      repeat (8) step();

      inst_req    = 1'b1;
      inst_cancel = 1'b1;
      inst_addr   = 32'h50;
      @(negedge clock);
      check("cancel_blocks_accept0", 128'(addr_ok[0]), 128'(0));
      check("cancel_blocks_accept1", 128'(addr_ok[1]), 128'(0));
      step();
      inst_req    = 1'b0;
      inst_cancel = 1'b0;
      repeat (4) step();

      inst_req  = 1'b1;
      inst_addr = 32'h20;
      step();
      inst_req = 1'b0;
      step();
      resetn = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) step();
      resetn = 1'b1;
      repeat (12) step();

      check("drain0", 128'(sbq[0].size()), 128'(0));
      check("drain1", 128'(sbq[1].size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
